// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues one data-memory request at a time,
// stalls until it completes, and returns the load word shifted down to bit 0.
module mem_access_stage #(
    parameter int unsigned ADDR_BITS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ex_valid_in,
    input  logic [1:0]           ex_mem_op_in,
    input  logic [2:0]           ex_funct3_in,
    input  logic [ADDR_BITS-1:0] ex_addr_in,
    input  logic [31:0]          ex_store_data_in,
    input  logic                 flush_in,
    output logic                 dmem_req_out,
    output logic                 dmem_we_out,
    output logic [ADDR_BITS-1:0] dmem_addr_out,
    output logic [31:0]          dmem_wdata_out,
    output logic [3:0]           dmem_be_out,
    input  logic                 dmem_ready_in,
    input  logic                 dmem_rvalid_in,
    input  logic [31:0]          dmem_rdata_in,
    output logic [31:0]          mem_data_out,
    output logic                 misalign_out,
    output logic                 stall_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t                 state_q, state_d;
    logic                   we_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [31:0]            wdata_q;
    logic [3:0]             be_q;
    logic [1:0]             off_q;
    logic [31:0]            mem_data_q;
    logic                   misalign_q, misalign_d;

    logic                   is_load, is_store, is_ls, aligned, take, capture, load_done;
    logic [1:0]             off;
    logic [ADDR_BITS-1:0]   ex_addr_w;
    logic [31:0]            ex_wdata;
    logic [3:0]             ex_be;

    // Decode of the Execute-side request, used directly in IDLE and captured for REQ.
    always_comb begin
        is_load   = (ex_mem_op_in == 2'd1);
        is_store  = (ex_mem_op_in == 2'd2);
        is_ls     = is_load || is_store;
        off       = ex_addr_in[1:0];
        ex_addr_w = {ex_addr_in[ADDR_BITS-1:2], 2'b00};
        aligned   = 1'b1;
        ex_wdata  = ex_store_data_in;
        ex_be     = 4'hF;
        case (ex_funct3_in)
            3'd0, 3'd4: begin
                ex_wdata = {4{ex_store_data_in[7:0]}};
                ex_be    = 4'b0001 << off;
            end
            3'd1, 3'd5: begin
                aligned  = ~ex_addr_in[0];
                ex_wdata = {2{ex_store_data_in[15:0]}};
                ex_be    = 4'b0011 << off;
            end
            default: begin
                aligned  = (off == 2'b00);
            end
        endcase
        if (is_load) begin
            ex_be = 4'hF;
        end
    end

    always_comb begin
        state_d        = state_q;
        take           = 1'b0;
        capture        = 1'b0;
        load_done      = 1'b0;
        misalign_d     = 1'b0;
        dmem_req_out   = 1'b0;
        dmem_we_out    = we_q;
        dmem_addr_out  = addr_q;
        dmem_wdata_out = wdata_q;
        dmem_be_out    = be_q;
        stall_out      = 1'b0;
        case (state_q)
            S_IDLE: begin
                dmem_we_out    = is_store;
                dmem_addr_out  = ex_addr_w;
                dmem_wdata_out = ex_wdata;
                dmem_be_out    = ex_be;
                if (ex_valid_in && is_ls && !flush_in) begin
                    take       = aligned;
                    misalign_d = !aligned;
                end
                if (take) begin
                    capture      = 1'b1;
                    dmem_req_out = 1'b1;
                    if (!dmem_ready_in) begin
                        state_d   = S_REQ;
                        stall_out = 1'b1;
                    end else if (is_load) begin
                        state_d   = S_WAIT;
                        stall_out = 1'b1;
                    end
                end
            end
            S_REQ: begin
                dmem_req_out = 1'b1;
                stall_out    = !(dmem_ready_in && we_q);
                if (dmem_ready_in) begin
                    state_d = we_q ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: begin
                stall_out = !dmem_rvalid_in;
                if (dmem_rvalid_in) begin
                    load_done = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            off_q      <= '0;
            mem_data_q <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            misalign_q <= misalign_d;
            if (capture) begin
                we_q    <= is_store;
                addr_q  <= ex_addr_w;
                wdata_q <= ex_wdata;
                be_q    <= ex_be;
                off_q   <= off;
            end
            if (load_done) begin
                mem_data_q <= dmem_rdata_in >> {off_q, 3'b000};
            end
        end
    end

    assign mem_data_out = mem_data_q;
    assign misalign_out = misalign_q;

endmodule
